// File: rtl/dmem_hs.sv
// Word-organised data memory with byte/half/word lanes, valid/ready request and
// response handshakes, configurable wait states and fault reporting.
module dmem_hs #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
    // The accept edge already counts as the first wait cycle.
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    function automatic logic fault_f(input logic [1:0] size, input logic [ADDR_WIDTH-1:0] addr);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || (addr[ADDR_WIDTH-1:2] >= DEPTH_W);
    endfunction

    function automatic logic [31:0] store_merge_f(input logic [31:0] old, input logic [31:0] wd,
                                                  input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = old;
        case (size)
            2'b00:   w[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   if (lane[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
            2'b10:   w = wd;
            default: w = old;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract_f(input logic [31:0] word, input logic [1:0] size,
                                                   input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic                  we_r;
    logic [1:0]            size_r;
    logic                  signed_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic [31:0]           rdata_r;
    logic                  err_r;
    logic [31:0]           mem_r [DEPTH];

    logic                  acc_we_s;
    logic [1:0]            acc_size_s;
    logic                  acc_signed_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [31:0]           acc_wdata_s;
    logic                  fault_s;
    logic                  access_s;
    logic                  mem_we_s;
    logic [IDX_W-1:0]      widx_s;
    logic [31:0]           rword_s;
    logic [31:0]           load_res_s;

    // Access fields: live inputs at the accept edge, latched copy afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s     = req_we;
            acc_size_s   = req_size;
            acc_signed_s = req_signed;
            acc_addr_s   = req_addr;
            acc_wdata_s  = req_wdata;
        end else begin
            acc_we_s     = we_r;
            acc_size_s   = size_r;
            acc_signed_s = signed_r;
            acc_addr_s   = addr_r;
            acc_wdata_s  = wdata_r;
        end
    end

    // Decide whether this edge is the memory access edge.
    always_comb begin
        access_s = 1'b0;
        case (state_r)
            ST_IDLE: access_s = req_valid && !fault_s && ZERO_WAIT;
            ST_WAIT: access_s = (cnt_r == 4'd0);
            default: access_s = 1'b0;
        endcase
    end

    assign fault_s    = fault_f(acc_size_s, acc_addr_s);
    assign widx_s     = acc_addr_s[IDX_W+1:2];
    assign rword_s    = mem_r[widx_s];
    assign load_res_s = acc_we_s ? 32'd0 : load_extract_f(rword_s, acc_size_s, acc_addr_s[1:0], acc_signed_s);
    // Reset wins over a store landing on the same edge.
    assign mem_we_s   = access_s && acc_we_s && reset_n;

    // Storage write with lane merge; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[widx_s] <= store_merge_f(rword_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
        end
    end

    // Request/response control FSM and registered response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            wdata_r  <= 32'd0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        if (fault_s) begin
                            state_r <= ST_RESP;
                            err_r   <= 1'b1;
                            rdata_r <= 32'd0;
                        end else if (ZERO_WAIT) begin
                            state_r <= ST_RESP;
                            err_r   <= 1'b0;
                            rdata_r <= load_res_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                        err_r   <= 1'b0;
                        rdata_r <= load_res_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r <= ST_IDLE;
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_r == ST_IDLE);
    assign resp_valid = (state_r == ST_RESP);
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: four instances (0/1/3/15 wait states) driven by directed and
// random transactions, checked against a byte-level memory model.
module tb_dmem_hs;

    logic        clk = 1'b0;
    logic        reset_n    [4];
    logic        req_valid  [4];
    logic        req_ready  [4];
    logic        req_we     [4];
    logic [1:0]  req_size   [4];
    logic        req_signed [4];
    logic [31:0] req_addr   [4];
    logic [31:0] req_wdata  [4];
    logic        resp_valid [4];
    logic        resp_ready [4];
    logic [31:0] resp_rdata [4];
    logic        resp_err   [4];

    logic [31:0] mdl [4][64];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_rd;
    logic        last_err;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        dmem_hs #(
            .ADDR_WIDTH (32),
            .DEPTH      (64),
            .WAIT_STATES(gi == 0 ? 0 : gi == 1 ? 1 : gi == 2 ? 3 : 15)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n[gi]),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_we    (req_we[gi]),
            .req_size  (req_size[gi]),
            .req_signed(req_signed[gi]),
            .req_addr  (req_addr[gi]),
            .req_wdata (req_wdata[gi]),
            .resp_valid(resp_valid[gi]),
            .resp_ready(resp_ready[gi]),
            .resp_rdata(resp_rdata[gi]),
            .resp_err  (resp_err[gi])
        );
    end

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        nb = 1 << sz;
        return (sz == 2'd3) || ((a % nb) != 0) || ((a >> 2) >= 32'd64);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input int nb, input int off, input logic sg);
        logic [31:0] v, mask;
        v    = w >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] wd, input int nb, input int off);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < nb; b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int t;
        t = 0;
        while (req_ready[i] !== 1'b1 && t < 64) begin @(negedge clk); t++; end
        if (t >= 64) chk("ready_timeout", 32'd0, 32'd1);
        req_we[i] = we; req_size[i] = sz; req_signed[i] = sg;
        req_addr[i] = a; req_wdata[i] = wd; req_valid[i] = 1'b1;
        @(posedge clk); #1;
        req_valid[i]  = 1'b0;
        req_we[i]     = 1'($urandom);
        req_size[i]   = 2'($urandom);
        req_signed[i] = 1'($urandom);
        req_addr[i]   = $urandom;
        req_wdata[i]  = $urandom;
        @(negedge clk);
        lat = 1;
        while (resp_valid[i] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        rd = resp_rdata[i];
        er = resp_err[i];
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 32'(req_ready[i]), 32'd1);
        chk("valid_after_hs", 32'(resp_valid[i]), 32'd0);
    endtask

    task automatic txn(input int i, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        flt;
        logic [31:0] exp_rd, rd;
        logic        er;
        int          nb, lat, exp_lat;
        nb      = 1 << sz;
        flt     = m_fault(sz, a);
        exp_rd  = (flt || we) ? 32'd0 : m_load(mdl[i][a[7:2]], nb, int'(a[1:0]), sg);
        exp_lat = flt ? 1 : ws_of(i) + 1;
        do_req(i, we, sz, sg, a, wd, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(flt));
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!flt && we) mdl[i][a[7:2]] = m_store(mdl[i][a[7:2]], wd, nb, int'(a[1:0]));
        last_rd  = rd;
        last_err = er;
    endtask

    initial begin
        logic [31:0] a, wd, rd0, old;
        logic [1:0]  sz;
        int          r, t;

        for (int i = 0; i < 4; i++) begin
            reset_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
            req_signed[i] = 1'b0; req_addr[i] = 32'd0; req_wdata[i] = 32'd0; resp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_resp_rdata", resp_rdata[i], 32'd0);
            chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            reset_n[i] = 1'b1;
        end

        // Fill every word so later partial accesses have defined neighbours.
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 64; w++) txn(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, "init_sw");

        // Basic word store/load and lane handling.
        txn(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00FF, "t1_sw");
        txn(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t1_lw");
        chk("t1_lw_const", last_rd, 32'h8000_00FF);
        txn(1, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_005A, "t2_sb");
        txn(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, "t2_lb13");
        chk("t2_lb13_const", last_rd, 32'h0000_005A);
        txn(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t2_lw");
        chk("t2_lw_const", last_rd, 32'h5A00_00FF);
        txn(1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, "t2_lh");
        chk("t2_lh_const", last_rd, 32'h0000_5A00);
        txn(1, 1'b0, 2'd0, 1'b0, 32'h10, 32'd0, "t2_lbu");
        chk("t2_lbu_const", last_rd, 32'h0000_00FF);
        txn(1, 1'b0, 2'd0, 1'b1, 32'h10, 32'd0, "t2_lb10");
        chk("t2_lb10_const", last_rd, 32'hFFFF_FFFF);

        // Faulting requests must not touch storage.
        txn(1, 1'b0, 2'd2, 1'b0, 32'h11, 32'd0, "t3_lw_mis");
        chk("t3_lw_mis_errc", 32'(last_err), 32'd1);
        txn(1, 1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_FFFF, "t3_sh_mis");
        txn(1, 1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFF_FFFF, "t3_size11");
        txn(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, "t3_range");
        chk("t3_range_errc", 32'(last_err), 32'd1);
        txn(1, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, "t3_lw0");

        // Backpressure: response held, request ignored while busy.
        req_we[1] = 1'b0; req_size[1] = 2'd2; req_signed[1] = 1'b0; req_addr[1] = 32'h10; req_valid[1] = 1'b1;
        @(posedge clk); #1; req_valid[1] = 1'b0;
        t = 0;
        while (resp_valid[1] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        rd0 = resp_rdata[1];
        chk("t4_rdata", rd0, mdl[1][4]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(resp_valid[1]), 32'd1);
            chk("t4_hold_rdata", resp_rdata[1], rd0);
            chk("t4_hold_ready", 32'(req_ready[1]), 32'd0);
            if (k == 1) begin
                req_we[1] = 1'b1; req_size[1] = 2'd2; req_addr[1] = 32'h0; req_wdata[1] = 32'hDEAD_BEEF; req_valid[1] = 1'b1;
            end
            if (k == 2) req_valid[1] = 1'b0;
        end
        resp_ready[1] = 1'b1;
        @(posedge clk); #1; resp_ready[1] = 1'b0;
        @(negedge clk);
        chk("t4_ready_after", 32'(req_ready[1]), 32'd1);
        chk("t4_valid_after", 32'(resp_valid[1]), 32'd0);
        txn(1, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, "t4_lw0");

        // Reset landing on the access edge of a store (3 wait states).
        old = mdl[2][2];
        req_we[2] = 1'b1; req_size[2] = 2'd2; req_addr[2] = 32'h8; req_wdata[2] = 32'h1234_5678; req_valid[2] = 1'b1;
        @(posedge clk); #1; req_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_valid", 32'(resp_valid[2]), 32'd0);
        chk("t5_rdata", resp_rdata[2], 32'd0);
        chk("t5_err", 32'(resp_err[2]), 32'd0);
        chk("t5_ready", 32'(req_ready[2]), 32'd1);
        reset_n[2] = 1'b1;
        txn(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, "t5_lw8");
        chk("t5_lw8_old", last_rd, old);

        // Back-to-back store/load at the wait-state extremes.
        txn(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, "t6_ws0_sw");
        txn(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "t6_ws0_lw");
        chk("t6_ws0_const", last_rd, 32'hCAFE_F00D);
        txn(3, 1'b1, 2'd2, 1'b0, 32'h24, 32'h0BAD_C0DE, "t6_ws15_sw");
        txn(3, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0, "t6_ws15_lw");
        chk("t6_ws15_const", last_rd, 32'h0BAD_C0DE);

        // Random mix of sizes, alignments, signs and occasional far addresses.
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < ((i == 3) ? 20 : 50); n++) begin
                r  = $urandom_range(0, 15);
                sz = (r == 15) ? 2'd3 : 2'(r % 3);
                a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
                if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                wd = $urandom;
                txn(i, 1'($urandom), sz, 1'($urandom), a, wd, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
